hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: register-number width and the hazard FSM state encoding.
package hazard_ctrl_pkg;

  // Width of a MIPS-style register specifier (rs/rt/rd).
  localparam int REG_W = 5;

  // Hazard controller states: normal issue, or holding EX for a multi-cycle multiply.
  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, multi-cycle multiply
// hold of ID/EX, taken-branch flushing, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             idex_memread_i,
  input  logic             idex_mul_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             idex_hold_o,
  output logic             exmem_flush_o,
  output logic             mul_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Multiply down-counter width; the first multiply cycle is spent in IDLE,
  // so MUL_BUSY covers MUL_CYCLES-1 cycles counting MUL_CYCLES-2 down to 0.
  localparam int              MC_W     = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  // Load-use comparator: a load in EX whose destination feeds the instruction in ID.
  always_comb begin
    load_use = idex_memread_i && (idex_rt_i != '0) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  end

  // Next-state and control outputs; branch overrides everything, multiply beats load-use.
  always_comb begin
    state_d       = state_q;
    mul_cnt_d     = mul_cnt_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    idex_hold_o   = 1'b0;
    exmem_flush_o = 1'b0;
    mul_done_o    = 1'b0;

    if (!rst_n) begin
      // Held in reset: the flops are cleared, outputs stay at their defaults.
      state_d   = IDLE;
      mul_cnt_d = '0;
    end else if (branch_taken_i) begin
      // Squash the three younger stages and let fetch redirect; abandons any multiply.
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      state_d       = IDLE;
      mul_cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (idex_mul_i) begin
            // First multiply cycle: freeze front end, hold EX, bubble into MEM.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_hold_o   = 1'b1;
            exmem_flush_o = 1'b1;
            state_d       = MUL_BUSY;
            mul_cnt_d     = MUL_LOAD;
          end else if (load_use) begin
            // One bubble so the loaded value can be forwarded from MEM/WB.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        MUL_BUSY: begin
          // The held instruction is the same multiply, so idex_mul_i is not consulted.
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_hold_o   = 1'b1;
          exmem_flush_o = 1'b1;
          if (mul_cnt_q == '0) begin
            mul_done_o = 1'b1;
            state_d    = IDLE;
          end else begin
            mul_cnt_d = mul_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          mul_cnt_d = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was frozen.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, multiply counter and statistics registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mul_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule : hazard_ctrl
